fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined ARM CPU. Holds the program counter, drives the instruction-memory address, captures the fetched word into the IF/ID register for the decode/control stage, and selects the next PC. Next-PC sources are sequential PC+4, an early-taken B/BL target decoded in fetch, and a redirect from the downstream branch-resolution stage. Also handles stall (hazard unit) and flush (mispredicted conditional branch or branch-register).

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- NOP_INSTR, 32'hD503201F, instruction word placed in IF/ID on bubble/flush
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- stall  input  1  hazard unit: hold PC and IF/ID unchanged this cycle
- redirect  input  1  downstream branch resolved taken / mispredict: load redirect_pc, flush IF/ID
- redirect_pc  input  64  redirect target
- imem_addr  output  64  instruction memory address (= PC register, combinational)
- imem_instr  input  32  instruction word at imem_addr (combinational read, same cycle)
- id_instr  output  32  IF/ID instruction
- id_pc  output  64  IF/ID PC of id_instr
- id_pc_plus4  output  64  IF/ID id_pc+4 (BL link value)
- id_valid  output  1  IF/ID holds a real instruction; 0 = bubble

## Operation
- Registers: pc[63:0], IF/ID {id_instr, id_pc, id_pc_plus4, id_valid}. No other state.
- Predecode of imem_instr (combinational): is_b = imem_instr[31:26]==6'b000101 (B) or 6'b100101 (BL).
- Branch target: br_tgt = pc + ({{36{imem_instr[25]}}, imem_instr[25:0], 2'b00}); 64-bit add, wraps mod 2^64.
- seq = pc + 64'd4, wraps mod 2^64.
- Per-edge update priority (highest first):
  1. reset==0: pc<=RESET_PC; id_instr<=NOP_INSTR; id_pc<=0; id_pc_plus4<=0; id_valid<=0.
  2. redirect==1: pc<=redirect_pc; id_instr<=NOP_INSTR; id_valid<=0; id_pc, id_pc_plus4 <=0. Redirect overrides stall.
  3. stall==1: pc and all IF/ID fields hold. A B/BL in fetch during stall is not taken until the stall clears.
  4. otherwise: id_instr<=imem_instr; id_pc<=pc; id_pc_plus4<=seq; id_valid<=1; pc<= is_b ? br_tgt : seq.
- Conditional branches (CBZ, B.cond) and BR are predicted not-taken; correction arrives only through redirect.
- B/BL taken in fetch causes zero bubbles; BL link value is carried in id_pc_plus4 (branch PC + 4).
- imem_addr = pc at all times, including during reset and stall.

## Timing
- Fetch latency: word at PC=P appears on id_instr one clock edge after pc==P, provided stall=0 and redirect=0 at that edge.
- Redirect: redirect_pc is on imem_addr the cycle after assertion; its instruction is in IF/ID two edges after assertion. Exactly one bubble (id_valid=0) is inserted by fetch for each redirect.
- Consecutive redirects: each is honoured in turn, and the last one wins.
- Stall held N cycles: outputs are frozen for N cycles and resume with no lost or duplicated instruction.
- Reset release: first edge with reset=1 latches the word at RESET_PC, so id_valid=1 after that edge.
- Reset mid-operation discards any pending branch, stall, or IF/ID contents.
- All outputs are registered except imem_addr, which is a direct copy of the pc register.

## Test plan
- Reset/sequential: reset=0 two cycles, then release with words at 0,4,8 all ADD. Expect id_pc = 0, 4, 8 on successive edges, id_valid=1 from the first edge after release, and imem_addr=0 during reset.
- B forward/backward: B with imm26=3 at PC 0x10 → next imem_addr 0x1C, no bubble. B with imm26=26'h3FFFFFF at 0x20 → 0x1C. BL at 0x40 → id_pc_plus4=0x44.
- Redirect: redirect=1, redirect_pc=0x100 at pc=0x8 → next edge id_valid=0, id_instr=32'hD503201F, imem_addr=0x100. Following edge id_pc=0x100.
- Stall: stall=1 for 3 cycles at pc=0xC → pc, id_* unchanged for 3 edges. Then id_pc=0xC, with no skip or duplicate.
- Stall+redirect and stall+B: stall=1 with redirect=1 (0x200) → pc=0x200, IF/ID flushed. stall=1 with B at fetch → pc holds; branch taken on the first unstalled edge.
- Wrap/reset mid-run: pc=64'hFFFF_FFFF_FFFF_FFFC sequential → pc=0. Reset asserted during a stall → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, predecodes B/BL for a zero-bubble taken path, and
// accepts stall and redirect from the hazard and branch-resolution logic.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [63:0] id_pc_plus4,
  output logic        id_valid
);

  logic [63:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [63:0] id_pc_q, id_pc_d;
  logic [63:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;

  logic        is_b;
  logic [63:0] br_tgt;
  logic [63:0] seq;

  // Predecode unconditional B/BL and form both candidate next PCs.
  always_comb begin
    is_b   = (imem_instr[31:26] == 6'b000101) || (imem_instr[31:26] == 6'b100101);
    br_tgt = pc_q + {{36{imem_instr[25]}}, imem_instr[25:0], 2'b00};
    seq    = pc_q + 64'd4;
  end

  // Next-state selection: redirect flushes and overrides stall; stall holds.
  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    if (redirect) begin
      pc_d          = redirect_pc;
      id_instr_d    = NOP_INSTR;
      id_pc_d       = 64'd0;
      id_pc_plus4_d = 64'd0;
      id_valid_d    = 1'b0;
    end else if (!stall) begin
      pc_d          = is_b ? br_tgt : seq;
      id_instr_d    = imem_instr;
      id_pc_d       = pc_q;
      id_pc_plus4_d = seq;
      id_valid_d    = 1'b1;
    end
  end

  // PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 64'd0;
      id_pc_plus4_q <= 64'd0;
      id_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;

endmodule
